// File: rtl/halt_pkg.sv
// Shared types and constants for the halt controller and its instruction classifier.
package halt_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } halt_state_t;

    typedef enum logic [2:0] {
        NONE     = 3'd0,
        ECALL    = 3'd1,
        EBREAK   = 3'd2,
        SELFLOOP = 3'd3,
        STUCK    = 3'd4,
        WATCHDOG = 3'd5
    } halt_cause_t;

    localparam logic [31:0] INSTR_ECALL    = 32'h0000_0073;
    localparam logic [31:0] INSTR_EBREAK   = 32'h0010_0073;
    localparam logic [31:0] INSTR_JAL_SELF = 32'h0000_006F;

    // Counter width for a limit p, never narrower than one bit.
    function automatic int cnt_width(input int p);
        return (p > 2) ? $clog2(p) : 1;
    endfunction

endpackage

// File: rtl/halt_decode.sv
// Priority classifier from a fetched instruction word to a terminating cause.
import halt_pkg::*;

module halt_decode (
    input  logic [31:0] i_instr,
    output halt_cause_t o_cause
);

    always_comb begin
        o_cause = NONE;
        if (i_instr == INSTR_EBREAK) begin
            o_cause = EBREAK;
        end else if (i_instr == INSTR_ECALL) begin
            o_cause = ECALL;
        end else if (i_instr == INSTR_JAL_SELF) begin
            o_cause = SELFLOOP;
        end
    end

endmodule

// File: rtl/halt_controller.sv
// Detects program termination, freezes the PC, records cause and cycle count, then drains to done.
import halt_pkg::*;

module halt_controller #(
    parameter int XLEN         = 32,
    parameter int MAX_CYCLES   = 10000,
    parameter int STALL_LIMIT  = 4,
    parameter int DRAIN_CYCLES = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] pc_reg,
    input  logic [31:0]     instr,
    output logic            finish_flag,
    output logic            done,
    output logic [2:0]      halt_cause,
    output logic [31:0]     cycle_count
);

    localparam int STALL_W = cnt_width(STALL_LIMIT);
    localparam int DRAIN_W = cnt_width(DRAIN_CYCLES);
    localparam logic [STALL_W-1:0] STALL_HIT  = STALL_W'(STALL_LIMIT - 2);
    localparam logic [STALL_W-1:0] STALL_ONE  = STALL_W'(1);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);
    localparam logic [DRAIN_W-1:0] DRAIN_ONE  = DRAIN_W'(1);
    localparam logic [31:0]        WD_LAST    = 32'(MAX_CYCLES - 1);
    localparam bit                 WD_EN      = (MAX_CYCLES != 0);

    halt_state_t        r_state, w_state_next;
    halt_cause_t        r_cause, w_cause_next;
    logic               r_finish, w_finish_next;
    logic               r_done, w_done_next;
    logic [31:0]        r_cycle_count, w_cycle_count_next;
    logic [DRAIN_W-1:0] r_drain_cnt, w_drain_cnt_next;
    logic [STALL_W-1:0] r_stall_cnt, w_stall_cnt_next;
    logic [XLEN-1:0]    r_prev_pc, w_prev_pc_next;
    logic               r_prev_pc_valid, w_prev_pc_valid_next;

    halt_cause_t w_instr_cause;
    halt_cause_t w_hit_cause;
    logic        w_same_pc;
    logic        w_stuck;
    logic        w_watchdog;

    halt_decode u_decode (
        .i_instr (instr),
        .o_cause (w_instr_cause)
    );

    assign w_same_pc  = r_prev_pc_valid && (pc_reg == r_prev_pc);
    assign w_stuck    = w_same_pc && (r_stall_cnt == STALL_HIT);
    assign w_watchdog = WD_EN && (r_cycle_count == WD_LAST);

    // Instruction causes outrank stuck, which outranks the watchdog.
    always_comb begin
        w_hit_cause = NONE;
        if (w_instr_cause != NONE) begin
            w_hit_cause = w_instr_cause;
        end else if (w_stuck) begin
            w_hit_cause = STUCK;
        end else if (w_watchdog) begin
            w_hit_cause = WATCHDOG;
        end
    end

    always_comb begin
        w_state_next         = r_state;
        w_cause_next         = r_cause;
        w_finish_next        = r_finish;
        w_done_next          = r_done;
        w_cycle_count_next   = r_cycle_count;
        w_drain_cnt_next     = r_drain_cnt;
        w_stall_cnt_next     = r_stall_cnt;
        w_prev_pc_next       = r_prev_pc;
        w_prev_pc_valid_next = r_prev_pc_valid;
        case (r_state)
            RUN: begin
                w_cycle_count_next   = r_cycle_count + 32'd1;
                w_prev_pc_next       = pc_reg;
                w_prev_pc_valid_next = 1'b1;
                w_stall_cnt_next     = w_same_pc ? (r_stall_cnt + STALL_ONE) : '0;
                if (w_hit_cause != NONE) begin
                    w_finish_next    = 1'b1;
                    w_cause_next     = w_hit_cause;
                    w_state_next     = DRAIN;
                    w_drain_cnt_next = '0;
                end
            end
            DRAIN: begin
                if (r_drain_cnt == DRAIN_LAST) begin
                    w_done_next  = 1'b1;
                    w_state_next = HALTED;
                end else begin
                    w_drain_cnt_next = r_drain_cnt + DRAIN_ONE;
                end
            end
            HALTED: begin
                w_state_next = HALTED;
            end
            default: begin
                w_state_next = RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= RUN;
            r_cause         <= NONE;
            r_finish        <= 1'b0;
            r_done          <= 1'b0;
            r_cycle_count   <= '0;
            r_drain_cnt     <= '0;
            r_stall_cnt     <= '0;
            r_prev_pc       <= '0;
            r_prev_pc_valid <= 1'b0;
        end else begin
            r_state         <= w_state_next;
            r_cause         <= w_cause_next;
            r_finish        <= w_finish_next;
            r_done          <= w_done_next;
            r_cycle_count   <= w_cycle_count_next;
            r_drain_cnt     <= w_drain_cnt_next;
            r_stall_cnt     <= w_stall_cnt_next;
            r_prev_pc       <= w_prev_pc_next;
            r_prev_pc_valid <= w_prev_pc_valid_next;
        end
    end

    assign finish_flag = r_finish;
    assign done        = r_done;
    assign halt_cause  = r_cause;
    assign cycle_count = r_cycle_count;

endmodule
